// File: rtl/reg_file_2r1w_if.sv
// Operand-fetch, write-back and flag signals between the datapath and the
// two-read/one-write register file.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              reg_write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              flag_write;
    logic              zero_in;
    logic              neg_in;
    logic              zero_q;
    logic              neg_q;
    logic [15:0]       wr_count;

    modport master (
        output reg_write, write_addr, write_data, read_addr1, read_addr2,
        output flag_write, zero_in, neg_in,
        input  read_data1, read_data2, zero_q, neg_q, wr_count
    );

    modport slave (
        input  reg_write, write_addr, write_data, read_addr1, read_addr2,
        input  flag_write, zero_in, neg_in,
        output read_data1, read_data2, zero_q, neg_q, wr_count
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// ALU operand register file: two combinational read ports with write-first
// bypass, one synchronous write port, hard-wired zero R0 and the flag register.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_file_2r1w_if.slave   rf
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              zero_r;
    logic              neg_r;
    logic [15:0]       wr_count_r;
    logic              wr_en_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // R0 is never a legal destination, so such writes are dropped entirely
    assign wr_en_s = rf.reg_write && (rf.write_addr != {ADDR_W{1'b0}});

    // Selects zero, the in-flight write-back value, or the stored register
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (addr == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Register array storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rf.write_addr] <= rf.write_data;
        end
    end

    // Committed-write counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_r <= 16'd0;
        end else if (wr_en_s) begin
            wr_count_r <= wr_count_r + 16'd1;
        end
    end

    // Architectural flags, no bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (rf.flag_write) begin
            zero_r <= rf.zero_in;
            neg_r  <= rf.neg_in;
        end
    end

    // Operand read ports
    always_comb begin
        rd1_s = read_sel(rf.read_addr1, rf.reg_write, rf.write_addr,
                         rf.write_data, regs_r[rf.read_addr1]);
        rd2_s = read_sel(rf.read_addr2, rf.reg_write, rf.write_addr,
                         rf.write_data, regs_r[rf.read_addr2]);
    end

    assign rf.read_data1 = rd1_s;
    assign rf.read_data2 = rd2_s;
    assign rf.zero_q     = zero_r;
    assign rf.neg_q      = neg_r;
    assign rf.wr_count   = wr_count_r;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: vector table through a scoreboard
// queue, plus hand sequences for reset, reset-during-write and counter wrap.
module tb_reg_file_2r1w;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(4)) rf_if ();

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        fw;
        logic        zi;
        logic        ni;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ez;
        logic        en;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ez;
        logic        en;
        logic [15:0] ecnt;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];
    exp_t e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic fw, input logic zi, input logic ni);
        rf_if.reg_write  = we;
        rf_if.write_addr = wa;
        rf_if.write_data = wd;
        rf_if.read_addr1 = ra1;
        rf_if.read_addr2 = ra2;
        rf_if.flag_write = fw;
        rf_if.zero_in    = zi;
        rf_if.neg_in     = ni;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        //           we   wa     wd            ra1    ra2    fw    zi    ni    e1            e2            ez    en    cnt
        vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd3,  4'd0,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 4'd0,  32'h00000000, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 16'd1};
        vecs[2] = '{1'b1, 4'd0,  32'h12345678, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 16'd1};
        vecs[3] = '{1'b0, 4'd0,  32'h00000000, 4'd0,  4'd3,  1'b0, 1'b0, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 16'd1};
        vecs[4] = '{1'b1, 4'd5,  32'hA5A5A5A5, 4'd5,  4'd5,  1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 16'd1};
        vecs[5] = '{1'b0, 4'd5,  32'h00000000, 4'd5,  4'd3,  1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 1'b1, 16'd2};
        vecs[6] = '{1'b1, 4'd15, 32'hFFFFFFFF, 4'd15, 4'd5,  1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 1'b1, 16'd2};
        vecs[7] = '{1'b1, 4'd15, 32'h01234567, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 32'h01234567, 32'h01234567, 1'b0, 1'b1, 16'd3};
        vecs[8] = '{1'b0, 4'd15, 32'h00000000, 4'd15, 4'd1,  1'b0, 1'b0, 1'b0, 32'h01234567, 32'h00000000, 1'b0, 1'b1, 16'd4};
        vecs[9] = '{1'b0, 4'd15, 32'hCAFEF00D, 4'd15, 4'd0,  1'b0, 1'b1, 1'b1, 32'h01234567, 32'h00000000, 1'b0, 1'b1, 16'd4};

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset_wr_count", {16'd0, rf_if.wr_count}, 32'd0);
        chk("reset_flags", {30'd0, rf_if.zero_q, rf_if.neg_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table through the scoreboard
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].fw, vecs[i].zi, vecs[i].ni);
            sb_q.push_back('{vecs[i].e1, vecs[i].e2, vecs[i].ez, vecs[i].en, vecs[i].ecnt});
            #1;
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_rd1", i), rf_if.read_data1, e.e1);
            chk($sformatf("vec%0d_rd2", i), rf_if.read_data2, e.e2);
            chk($sformatf("vec%0d_zero", i), {31'd0, rf_if.zero_q}, {31'd0, e.ez});
            chk($sformatf("vec%0d_neg", i), {31'd0, rf_if.neg_q}, {31'd0, e.en});
            chk($sformatf("vec%0d_cnt", i), {16'd0, rf_if.wr_count}, {16'd0, e.ecnt});
        end

        // Mid-cycle reset pulse clears everything before the next edge
        @(posedge clk);
        #2;
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd15, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_count", {16'd0, rf_if.wr_count}, 32'd0);
        chk("midrst_flags", {30'd0, rf_if.zero_q, rf_if.neg_q}, 32'd0);
        chk("midrst_r3", rf_if.read_data1, 32'd0);
        chk("midrst_r15", rf_if.read_data2, 32'd0);
        for (int r = 1; r < 16; r++) begin
            rf_if.read_addr1 = 4'(r);
            rf_if.read_addr2 = 4'(r);
            #0.1;
            chk($sformatf("midrst_reg%0d_p1", r), rf_if.read_data1, 32'd0);
            chk($sformatf("midrst_reg%0d_p2", r), rf_if.read_data2, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while a write to R7 is pending
        @(negedge clk);
        drive(1'b1, 4'd7, 32'h77777777, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pend_bypass", rf_if.read_data1, 32'h77777777);
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 4'd7, 32'h0, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("pend_lost_r7", rf_if.read_data1, 32'd0);
        chk("pend_lost_cnt", {16'd0, rf_if.wr_count}, 32'd0);
        @(negedge clk);
        drive(1'b1, 4'd7, 32'h13579BDF, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd7, 32'h0, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rel_r7", rf_if.read_data1, 32'h13579BDF);
        chk("post_rel_cnt", {16'd0, rf_if.wr_count}, 32'd1);

        // Counter wrap: 65534 more writes reach 16'hFFFF, one more wraps to 0
        for (int k = 0; k < 65534; k++) begin
            @(negedge clk);
            drive(1'b1, 4'd2, 32'(k), 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 4'd2, 32'h0, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap_cnt_max", {16'd0, rf_if.wr_count}, 32'h0000FFFF);
        chk("wrap_r2", rf_if.read_data1, 32'd65533);
        chk("wrap_r7", rf_if.read_data2, 32'h13579BDF);
        @(negedge clk);
        drive(1'b1, 4'd2, 32'h0, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd2, 32'h0, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap_cnt_zero", {16'd0, rf_if.wr_count}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
